keymgr_op_scheduler: RTL
========================

// Module: keymgr_op_scheduler
// PURPOSE
//  Shares the single key-manager operation port between NUM_REQ requesters (e.g. SW CSR path, HW sideload).
//  Round-robin arbitration; one op in flight at a time.
//  Gates each op against the current key-manager control state before issuing it.
//  Drives the op_start/op_done handshake and reports completion, rejection or timeout per requester.
// PARAMETERS
//  NUM_REQ         2    number of requesters (>=2)
//  TIMEOUT_CYCLES  256  max ISSUE cycles waiting for op_done_i before abort
//  CNT_W           $clog2(TIMEOUT_CYCLES+1)  timeout counter width (derived)
// PORTS
//  clk           in   1          single clock, rising edge
//  rst           in   1          asynchronous, active-high reset
//  req_i         in   NUM_REQ    per-requester op request; held until ack_o
//  req_op_i      in   3*NUM_REQ  per-requester op code; slice i = [3i+2:3i]
//  ack_o         out  NUM_REQ    one-cycle completion pulse to granted requester
//  err_o         out  NUM_REQ    qualifies ack_o: op rejected or timed out
//  ctrl_state_i  in   10         key-manager control state encoding
//  op_start_o    out  1          op valid to key manager; held until op_done_i or timeout
//  op_o          out  3          op code to key manager; stable while op_start_o=1
//  op_done_i     in   1          key-manager completion; sampled only in ISSUE
//  busy_o        out  1          FSM not in IDLE
// BEHAVIOUR
//  Op codes: Advance=0, GenId=1, GenSwOut=2, GenHwOut=3, Disable=4; codes 5-7 are always illegal.
//  State encodings: Reset=10'b1101100001, Init=10'b0100000100, OwnerKey=10'b1101111110.
//  Legality is evaluated against ctrl_state_i at accept time:
//   - Reset, Init: Advance and Disable only.
//   - OwnerKey: codes 0-4.
//   - Any other encoding: Disable only.
//  FSM states: IDLE, ISSUE, RESP. Reset drives IDLE and rr_ptr=0. Every output resets to 0.
//  IDLE, with some req_i set:
//   - Grant the first set bit searching from rr_ptr upward, wrapping modulo NUM_REQ.
//   - Latch grant index, op and legal flag.
//   - Legal -> ISSUE. Illegal -> RESP with err=1; nothing is issued.
//  ISSUE:
//   - op_start_o=1 and op_o=latched op; timeout counter increments each cycle.
//   - op_done_i=1 -> RESP with err=0. This takes priority over timeout in the same cycle.
//   - Counter reaches TIMEOUT_CYCLES-1 without op_done_i -> RESP with err=1.
//  RESP:
//   - One cycle: ack_o[idx]=1 and err_o[idx]=err; all other bits 0.
//   - rr_ptr <= (idx+1) mod NUM_REQ. Counter cleared. Next state IDLE.
//  Latency:
//   - Accept in cycle T -> op_start_o high from T+1.
//   - op_done_i seen in cycle T+1+n -> ack_o in T+2+n.
//   - Illegal op -> ack_o+err_o in T+1.
//  op_done_i outside ISSUE is ignored.
//  op_start_o drops in the cycle after op_done_i or timeout.
//  req_i deasserted after grant: the op still completes and ack_o still pulses.
//  A request seen in IDLE the cycle after its ack_o is a new request.
//  ctrl_state_i changing during ISSUE does not abort the op; legality is checked only at accept.
//  Reset mid-op: op_start_o, ack_o, err_o and busy_o clear asynchronously; no ack is issued for the lost op.
// TESTING
//  1 Reset: hold rst 3 cycles, then release.
//    -> all outputs 0, busy_o=0. rr_ptr=0 is checked by test 3 granting req0 first.
//  2 State OwnerKey; req0 GenId; op_done_i 3 cycles after op_start_o rises.
//    -> op_o=1 held 4 cycles; ack_o=01, err_o=00 in the following cycle.
//  3 req0 and req1 both held with legal ops, op_done after 1 cycle, for 4 back-to-back ops.
//    -> grant order 0,1,0,1; each ack_o pulse is exactly 1 cycle.
//  4 State Reset; req1 GenHwOut (3); also op=6 in OwnerKey.
//    -> op_start_o never rises; ack_o=10, err_o=10 one cycle after accept, both cases.
//  5 State OwnerKey; req0 Advance with op_done_i never asserted, TIMEOUT_CYCLES=8.
//    -> op_start_o high exactly 8 cycles, then ack_o[0]=err_o[0]=1.
//    -> Repeat with op_done_i in cycle 8: err_o=0.
//  6 Assert rst in the 2nd ISSUE cycle.
//    -> op_start_o=0 immediately, no ack_o. After release, the same req0 re-grants and completes normally.

Source files
------------

// File: rtl/keymgr_op_scheduler.sv
// Round-robin scheduler sharing the key-manager op port.
// Gates each op on control state, tracks done/timeout, reports ack/err.
module keymgr_op_scheduler #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [3*NUM_REQ-1:0] req_op_i,
  output logic [NUM_REQ-1:0]   ack_o,
  output logic [NUM_REQ-1:0]   err_o,
  input  logic [9:0]           ctrl_state_i,
  output logic                 op_start_o,
  output logic [2:0]           op_o,
  input  logic                 op_done_i,
  output logic                 busy_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  localparam logic [9:0] ST_RESET = 10'b1101100001;
  localparam logic [9:0] ST_INIT  = 10'b0100000100;
  localparam logic [9:0] ST_OWNER = 10'b1101111110;

  localparam logic [2:0] OP_ADV = 3'd0;
  localparam logic [2:0] OP_DIS = 3'd4;

  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;

  logic [2:0]       req_op [NUM_REQ];
  logic             gnt_vld;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] cand;
  logic [2:0]       gnt_op;
  logic             gnt_legal;
  logic [IDX_W-1:0] nxt_ptr;

  function automatic logic op_legal(
    input logic [2:0] op,
    input logic [9:0] st
  );
    logic ok;
    unique case (1'b1)
      (st == ST_OWNER):
        ok = (op <= OP_DIS);
      (st == ST_RESET || st == ST_INIT):
        ok = (op == OP_ADV) || (op == OP_DIS);
      default:
        ok = (op == OP_DIS);
    endcase
    return ok;
  endfunction

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      req_op[k] = req_op_i[3*k +: 3];
    end
  end

  // First requester at or above rr_ptr, wrapping.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    gnt_op  = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!gnt_vld && req_i[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
        gnt_op  = req_op[cand];
      end
    end
  end

  assign gnt_legal = op_legal(gnt_op, ctrl_state_i);

  assign nxt_ptr = (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      idx        <= '0;
      cnt        <= '0;
      op_start_o <= 1'b0;
      op_o       <= '0;
      ack_o      <= '0;
      err_o      <= '0;
      busy_o     <= 1'b0;
    end else begin
      ack_o <= '0;
      err_o <= '0;
      unique case (state)
        IDLE: begin
          if (gnt_vld) begin
            idx    <= gnt_idx;
            busy_o <= 1'b1;
            if (gnt_legal) begin
              state      <= ISSUE;
              op_start_o <= 1'b1;
              op_o       <= gnt_op;
            end else begin
              state <= RESP;
              ack_o <= ONE << gnt_idx;
              err_o <= ONE << gnt_idx;
            end
          end
        end
        ISSUE: begin
          if (op_done_i) begin
            state      <= RESP;
            op_start_o <= 1'b0;
            op_o       <= '0;
            ack_o      <= ONE << idx;
          end else if (cnt == CNT_MAX) begin
            state      <= RESP;
            op_start_o <= 1'b0;
            op_o       <= '0;
            ack_o      <= ONE << idx;
            err_o      <= ONE << idx;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          state  <= IDLE;
          busy_o <= 1'b0;
          cnt    <= '0;
          rr_ptr <= nxt_ptr;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
